get_bit: RTL and testbench
==========================

// Module: get_bit
// PURPOSE
//  MSB-first bitstream reader: the decode-side counterpart of set_bit. Accepts a byte stream and returns
//  fields of 1..32 bits on request, plus a 32-bit peek window with a leading-zero count.
//  Sits between the slice byte source and the DC/AC Golomb/Rice entropy decoders of the ProRes decoder path.
// PARAMETERS
//  BUF_BITS   64  bit-buffer depth; must be >= MAX_FIELD+8 and a multiple of 8
//  MAX_FIELD  32  largest field size one request may consume
// PORTS
//  CLOCK            in   1   single clock, all logic on rising edge
//  RESET            in   1   synchronous, active-high
//  in_valid         in   1   in_byte presented
//  in_byte          in   8   stream byte, bit 7 is first in stream order
//  in_ready         out  1   byte accepted this edge when in_valid && in_ready
//  req_enable       in   1   consume request
//  req_size_of_bit  in   6   bits to consume, 0..32
//  req_align        in   1   with req_enable: discard up to next byte boundary, size ignored
//  req_ready        out  1   request accepted this edge when req_enable && req_ready
//  out_valid        out  1   one-cycle pulse, out_val holds the consumed field
//  out_val          out  32  field, right-justified, upper bits zero
//  peek_val         out  32  next 32 unconsumed bits, MSB-aligned, zero beyond bits_available
//  leading_zeros    out  6   leading zeros of peek_val, 0..32
//  bits_available   out  7   valid bits buffered, 0..BUF_BITS
//  bit_phase        out  3   total bits consumed mod 8
//  err              out  1   sticky: illegal request size seen
// BEHAVIOUR
//  - Reset: buffer cleared, bits_available=0, bit_phase=0, out_valid=0, out_val=0, err=0.
//    in_ready=1 and req_ready=0 the cycle after reset. RESET mid-stream discards all buffered bits
//    and any in-flight result; no out_valid is generated for an in-flight request.
//  - Storage is a BUF_BITS register holding valid bits MSB-aligned at the top, with count cnt.
//    Bits below cnt are always zero.
//  - in_ready  = (cnt <= BUF_BITS-8), computed from the current cnt only (no consume look-ahead).
//  - req_ready = legal && (cnt >= need). For a normal request need = req_size_of_bit; for an align
//    request need = (8-bit_phase)%8. legal = req_align || req_size_of_bit <= MAX_FIELD.
//  - A normal request accepted with size n loads out_val = top n bits, right-justified, and pulses
//    out_valid=1 on the next cycle (latency 1). The buffer shifts left by n with zero fill. bit_phase += n mod 8.
//  - Size 0: accepted, out_valid pulses with out_val=0, no shift.
//  - An align request shifts by need and produces no out_valid. With bit_phase=0 it is a no-op and is
//    accepted immediately.
//  - Sizes 33..63: req_ready=0 for that size and err is set to 1 on the next edge. err is cleared only by RESET.
//  - Simultaneous byte accept and consume in the same edge: consume first, then append the byte at
//    position cnt-n from the top. new cnt = cnt - n + 8.
//  - out_val holds its value between pulses. peek_val, leading_zeros, bits_available and bit_phase are
//    registered state views; they update on the same edge as the buffer.
//  - leading_zeros = 32 when peek_val==0. Decoders must qualify it against bits_available.
//  - No reordering or skipping is performed. Requests are served strictly in stream order.
// TESTING
//  1 Field extract: push 0xA5,0x3C; requests 4,8,4 -> out_val 0xA, 0x53, 0xC; bits_available 0; bit_phase 0.
//  2 Align: push 0xE0,0x81; request 3 (->0x7); align -> no out_valid, bit_phase 0; request 8 -> 0x81.
//  3 Full/simultaneous: push 7 bytes (cnt=56); next edge push byte + request 8 together ->
//    both accepted, cnt stays 56. Then push one byte -> cnt=64, in_ready=0 until a consume.
//  4 Peek/LZ: push 0x00,0x1F -> peek_val=0x001F0000, leading_zeros=11; request 11 -> 0x000, leading_zeros=0.
//  5 Illegal/underflow: cnt=4, request 8 -> req_ready=0, no state change. Request size 33 -> err=1 sticky,
//    no consume. Request 0 -> out_valid with 0.
//  6 Reset mid-operation: RESET asserted the cycle after a request is accepted -> no out_valid,
//    bits_available=0, err=0, out_val=0.

Source files
------------

// File: rtl/get_bit.sv
// MSB-first bitstream reader: buffers incoming bytes and hands out 1..32 bit fields on request,
// with a registered 32-bit peek window and leading-zero count for Golomb/Rice decoders.
module get_bit #(
    parameter int unsigned BUF_BITS  = 64,
    parameter int unsigned MAX_FIELD = 32
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    input  logic        req_enable,
    input  logic [5:0]  req_size_of_bit,
    input  logic        req_align,
    output logic        req_ready,
    output logic        out_valid,
    output logic [31:0] out_val,
    output logic [31:0] peek_val,
    output logic [5:0]  leading_zeros,
    output logic [6:0]  bits_available,
    output logic [2:0]  bit_phase,
    output logic        err
);

    logic [BUF_BITS-1:0] buf_q, buf_d;
    logic [6:0]          cnt_q, cnt_d;
    logic [2:0]          phase_q, phase_d;
    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_val_q, out_val_d;
    logic [31:0]         peek_q, peek_d;
    logic [5:0]          lz_q, lz_d;
    logic                err_q, err_d;

    logic                legal;
    logic [2:0]          align_need;
    logic [6:0]          need;
    logic                consume;
    logic                push;
    logic [6:0]          shift;
    logic [BUF_BITS-1:0] byte_vec;
    logic [31:0]         top_bits;
    logic [31:0]         field;

    function automatic logic [5:0] count_lz(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd32;
        // Ascending scan: the highest set bit is the last one to write n.
        for (int i = 0; i < 32; i++) begin
            if (v[i]) n = 6'(31 - i);
        end
        return n;
    endfunction

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        align_need = 3'd0 - phase_q;
        legal      = req_align || (req_size_of_bit <= 6'(MAX_FIELD));
        need       = req_align ? {4'd0, align_need} : {1'b0, req_size_of_bit};
        req_ready  = legal && (cnt_q >= need);
        in_ready   = (cnt_q <= 7'(BUF_BITS - 8));

        consume    = req_enable && req_ready;
        push       = in_valid && in_ready;
        shift      = consume ? need : 7'd0;

        // Consume happens first; the new byte lands right after the surviving bits.
        byte_vec   = {in_byte, {(BUF_BITS-8){1'b0}}} >> (cnt_q - shift);
        buf_d      = (buf_q << shift) | (push ? byte_vec : '0);
        cnt_d      = cnt_q - shift + (push ? 7'd8 : 7'd0);
        phase_d    = phase_q + shift[2:0];

        top_bits   = buf_q[BUF_BITS-1 -: 32];
        field      = 32'({32'd0, top_bits} >> (7'd32 - need));

        out_valid_d = consume && !req_align;
        out_val_d   = out_valid_d ? field : out_val_q;
        err_d       = err_q || (req_enable && !legal);

        // Bits below cnt are always zero, so the peek window needs no masking.
        peek_d     = buf_d[BUF_BITS-1 -: 32];
        lz_d       = count_lz(peek_d);
    end

    // NOTE: sequential state uses non-blocking assignments only; the bit buffer is reset
    // because stale bits would otherwise leak into peek_val.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            buf_q       <= '0;
            cnt_q       <= '0;
            phase_q     <= '0;
            out_valid_q <= 1'b0;
            out_val_q   <= '0;
            peek_q      <= '0;
            lz_q        <= 6'd32;
            err_q       <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            out_valid_q <= out_valid_d;
            out_val_q   <= out_val_d;
            peek_q      <= peek_d;
            lz_q        <= lz_d;
            err_q       <= err_d;
        end
    end

    // A reset arriving while a result is in flight suppresses that result's pulse.
    assign out_valid      = out_valid_q && !RESET;
    assign out_val        = out_val_q;
    assign peek_val       = peek_q;
    assign leading_zeros  = lz_q;
    assign bits_available = cnt_q;
    assign bit_phase      = phase_q;
    assign err            = err_q;

endmodule

// File: tb/tb_get_bit.sv
// Directed self-checking bench for get_bit: field extraction, alignment, full buffer,
// peek/leading-zero view, illegal sizes and reset in flight.
module tb_get_bit;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        req_enable;
    logic [5:0]  req_size_of_bit;
    logic        req_align;
    logic        req_ready;
    logic        out_valid;
    logic [31:0] out_val;
    logic [31:0] peek_val;
    logic [5:0]  leading_zeros;
    logic [6:0]  bits_available;
    logic [2:0]  bit_phase;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    get_bit #(.BUF_BITS(64), .MAX_FIELD(32)) dut (
        .CLOCK           (CLOCK),
        .RESET           (RESET),
        .in_valid        (in_valid),
        .in_byte         (in_byte),
        .in_ready        (in_ready),
        .req_enable      (req_enable),
        .req_size_of_bit (req_size_of_bit),
        .req_align       (req_align),
        .req_ready       (req_ready),
        .out_valid       (out_valid),
        .out_val         (out_val),
        .peek_val        (peek_val),
        .leading_zeros   (leading_zeros),
        .bits_available  (bits_available),
        .bit_phase       (bit_phase),
        .err             (err)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        step();
        in_valid = 1'b0;
    endtask

    // Presents a request, checks req_ready mid-cycle, then lets one edge pass.
    task automatic do_req(input string tag, input logic [5:0] size, input logic align,
                          input logic exp_rdy);
        req_enable      = 1'b1;
        req_size_of_bit = size;
        req_align       = align;
        @(negedge CLOCK);
        check({tag, ".req_ready"}, req_ready, exp_rdy);
        step();
        req_enable      = 1'b0;
        req_align       = 1'b0;
        req_size_of_bit = 6'd1;
    endtask

    task automatic expect_field(input string tag, input logic [31:0] val);
        check({tag, ".out_valid"}, out_valid, 1'b1);
        check({tag, ".out_val"}, out_val, val);
    endtask

    initial begin
        in_valid        = 1'b0;
        in_byte         = 8'h00;
        req_enable      = 1'b0;
        req_size_of_bit = 6'd1;
        req_align       = 1'b0;

        // Reset state
        do_reset();
        check("rst.bits_available", bits_available, 7'd0);
        check("rst.bit_phase", bit_phase, 3'd0);
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.out_val", out_val, 32'd0);
        check("rst.err", err, 1'b0);
        check("rst.in_ready", in_ready, 1'b1);
        check("rst.req_ready", req_ready, 1'b0);

        // 1: field extract
        push(8'hA5);
        push(8'h3C);
        check("t1.bits_available", bits_available, 7'd16);
        check("t1.peek", peek_val, 32'hA53C_0000);
        do_req("t1.r4a", 6'd4, 1'b0, 1'b1);
        expect_field("t1.r4a", 32'hA);
        check("t1.phase4", bit_phase, 3'd4);
        do_req("t1.r8", 6'd8, 1'b0, 1'b1);
        expect_field("t1.r8", 32'h53);
        do_req("t1.r4b", 6'd4, 1'b0, 1'b1);
        expect_field("t1.r4b", 32'hC);
        check("t1.bits_available_end", bits_available, 7'd0);
        check("t1.bit_phase_end", bit_phase, 3'd0);
        step();
        check("t1.pulse_one_cycle", out_valid, 1'b0);
        check("t1.out_val_held", out_val, 32'hC);

        // 2: align
        do_reset();
        push(8'hE0);
        push(8'h81);
        do_req("t2.r3", 6'd3, 1'b0, 1'b1);
        expect_field("t2.r3", 32'h7);
        check("t2.phase3", bit_phase, 3'd3);
        do_req("t2.align", 6'd0, 1'b1, 1'b1);
        check("t2.align.out_valid", out_valid, 1'b0);
        check("t2.align.bit_phase", bit_phase, 3'd0);
        check("t2.align.bits_available", bits_available, 7'd8);
        check("t2.align.peek", peek_val, 32'h8100_0000);
        do_req("t2.align_noop", 6'd0, 1'b1, 1'b1);
        check("t2.align_noop.bits_available", bits_available, 7'd8);
        do_req("t2.r8", 6'd8, 1'b0, 1'b1);
        expect_field("t2.r8", 32'h81);

        // 3: full buffer and simultaneous push/consume
        do_reset();
        for (int i = 1; i <= 7; i++) push(8'(i));
        check("t3.cnt56", bits_available, 7'd56);
        check("t3.in_ready56", in_ready, 1'b1);
        in_valid = 1'b1;
        in_byte  = 8'h08;
        do_req("t3.sim", 6'd8, 1'b0, 1'b1);
        in_valid = 1'b0;
        expect_field("t3.sim", 32'h01);
        check("t3.sim.cnt", bits_available, 7'd56);
        push(8'h09);
        check("t3.cnt64", bits_available, 7'd64);
        check("t3.in_ready64", in_ready, 1'b0);
        in_valid = 1'b1;
        in_byte  = 8'hFF;
        step();
        in_valid = 1'b0;
        check("t3.full_hold.cnt", bits_available, 7'd64);
        check("t3.full_peek", peek_val, 32'h0203_0405);
        do_req("t3.drain", 6'd8, 1'b0, 1'b1);
        expect_field("t3.drain", 32'h02);
        check("t3.drain.in_ready", in_ready, 1'b1);

        // 4: peek and leading zeros
        do_reset();
        check("t4.lz_empty", leading_zeros, 6'd32);
        push(8'h00);
        push(8'h1F);
        check("t4.peek", peek_val, 32'h001F_0000);
        check("t4.lz", leading_zeros, 6'd11);
        do_req("t4.r11", 6'd11, 1'b0, 1'b1);
        expect_field("t4.r11", 32'h000);
        check("t4.peek_after", peek_val, 32'hF800_0000);
        check("t4.lz_after", leading_zeros, 6'd0);
        check("t4.cnt_after", bits_available, 7'd5);

        // 5: underflow, illegal size, size 0
        do_reset();
        push(8'hB0);
        do_req("t5.r4", 6'd4, 1'b0, 1'b1);
        expect_field("t5.r4", 32'hB);
        do_req("t5.under", 6'd8, 1'b0, 1'b0);
        check("t5.under.out_valid", out_valid, 1'b0);
        check("t5.under.cnt", bits_available, 7'd4);
        check("t5.under.err", err, 1'b0);
        do_req("t5.s33", 6'd33, 1'b0, 1'b0);
        check("t5.s33.err", err, 1'b1);
        check("t5.s33.cnt", bits_available, 7'd4);
        check("t5.s33.out_valid", out_valid, 1'b0);
        do_req("t5.s0", 6'd0, 1'b0, 1'b1);
        expect_field("t5.s0", 32'h0);
        check("t5.s0.cnt", bits_available, 7'd4);
        step();
        check("t5.err_sticky", err, 1'b1);

        // 6: 32-bit boundary field, then reset while a result is in flight
        do_reset();
        push(8'hDE);
        push(8'hAD);
        push(8'hBE);
        push(8'hEF);
        do_req("t6.r32", 6'd32, 1'b0, 1'b1);
        expect_field("t6.r32", 32'hDEAD_BEEF);
        check("t6.r32.phase", bit_phase, 3'd0);
        do_req("t6.s40", 6'd40, 1'b0, 1'b0);
        check("t6.s40.err", err, 1'b1);
        push(8'h12);
        req_enable      = 1'b1;
        req_size_of_bit = 6'd8;
        step();
        req_enable      = 1'b0;
        req_size_of_bit = 6'd1;
        RESET           = 1'b1;
        @(negedge CLOCK);
        check("t6.flight.out_valid", out_valid, 1'b0);
        step();
        RESET = 1'b0;
        check("t6.post.out_valid", out_valid, 1'b0);
        check("t6.post.bits_available", bits_available, 7'd0);
        check("t6.post.err", err, 1'b0);
        check("t6.post.out_val", out_val, 32'd0);
        check("t6.post.req_ready", req_ready, 1'b0);
        step();
        check("t6.post2.out_valid", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
